// File: rtl/input_mem_pkg.sv
// Shared constants and state encoding for the input-memory fetch controller.
package input_mem_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;
  localparam int LEN_W  = 7;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] l);
    return (l > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : l;
  endfunction
endpackage

// File: rtl/fifo2_buf.sv
// Two-entry synchronous FIFO that absorbs the memory read latency under backpressure.
module fifo2_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  logic [W-1:0] ent_q [2];
  logic [W-1:0] ent_d [2];
  logic         wr_q, wr_d, rd_q, rd_d;
  logic [1:0]   cnt_q, cnt_d;

  always_comb begin
    ent_d = ent_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = 1'b0;
      rd_d  = 1'b0;
      cnt_d = 2'd0;
    end else begin
      if (push) begin
        ent_d[wr_q] = push_data;
        wr_d        = ~wr_q;
      end
      if (pop) rd_d = ~rd_q;
      cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      ent_q <= ent_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign count     = cnt_q;
  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = ent_q[rd_q];
endmodule

// File: rtl/input_mem_fetch_ctrl.sv
// Burst reader for the 64x32 input memory; streams words downstream over valid/ready.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | issuing reads (throttled by buffer occupancy)
//   DRAIN | all reads issued, waiting for the last word to be accepted
//   DONE  | one-cycle completion pulse
module input_mem_fetch_ctrl
  import input_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  iss_rem_q, iss_rem_d;
  logic [LEN_W-1:0]  emit_rem_q, emit_rem_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic [LEN_W-1:0]  len_sat;
  logic [1:0]        count;
  logic              pop, issue, push;
  logic [DATA_W:0]   head;

  assign len_sat = sat_len(len);
  assign pop     = out_valid && out_ready;
  // Occupancy-after-this-cycle check keeps the 2-entry buffer from ever overflowing.
  assign issue   = (state_q == ST_RUN) && !abort &&
                   (({1'b0, count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
  assign push    = inflight_q && !abort;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    iss_rem_d       = iss_rem_q;
    emit_rem_d      = emit_rem_q;
    inflight_d      = issue;
    inflight_last_d = issue && (iss_rem_q == 7'd1);
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          addr_d     = base_addr;
          iss_rem_d  = len_sat;
          emit_rem_d = len_sat;
          state_d    = (len_sat == '0) ? ST_DONE : ST_RUN;
        end
        ST_RUN: if (issue) begin
          iss_rem_d = iss_rem_q - 7'd1;
          if (iss_rem_q == 7'd1) state_d = ST_DRAIN;
          else                   addr_d  = addr_q + 6'd1;
        end
        ST_DRAIN: if (pop && emit_rem_q == 7'd1) state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
      if (pop && emit_rem_q != '0) emit_rem_d = emit_rem_q - 7'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      iss_rem_q       <= '0;
      emit_rem_q      <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      iss_rem_q       <= iss_rem_d;
      emit_rem_q      <= emit_rem_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  fifo2_buf #(.W(DATA_W + 1)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({inflight_last_q, mem_data}),
    .pop       (pop),
    .flush     (abort),
    .count     (count),
    .out_valid (out_valid),
    .out_data  (head)
  );

  assign out_data = head[DATA_W-1:0];
  assign out_last = head[DATA_W];
  assign mem_en   = issue;
  assign mem_addr = addr_q;
  assign busy     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done     = (state_q == ST_DONE);
endmodule
